// File: rtl/uart_bus_master_pkg.sv
// Shared constants for the UART-to-bus bridge: command opcodes, response codes,
// FSM state encodings, response lengths and the command decoder.
package uart_bus_master_pkg;

   // Command opcodes (upper nibble of the command byte)
   localparam logic [3:0] OP_READ  = 4'hA;
   localparam logic [3:0] OP_WRITE = 4'hB;

   // Single-byte responses
   localparam logic [7:0] RESP_ACK = 8'h06;
   localparam logic [7:0] RESP_NAK = 8'h15;

   // Bridge FSM states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DATA   = 3'd1;
   localparam logic [2:0] ST_BUS    = 3'd2;
   localparam logic [2:0] ST_RESP   = 3'd3;
   localparam logic [2:0] ST_TXWAIT = 3'd4;

   // Response byte counts
   localparam logic [2:0] RESP_LEN_READ  = 3'd4;
   localparam logic [2:0] RESP_LEN_SHORT = 3'd1;

   // Serial receiver states
   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_HOLD  = 3'd4;

   typedef enum logic [1:0] {
      CMD_READ,
      CMD_WRITE,
      CMD_INVALID
   } cmd_kind_e;

   // Classify a command byte by its opcode nibble
   function automatic cmd_kind_e decode_cmd(input logic [7:0] cmd);
      case (cmd[7:4])
         OP_READ:  return CMD_READ;
         OP_WRITE: return CMD_WRITE;
         default:  return CMD_INVALID;
      endcase
   endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// Peripheral bus between the bridge (master) and a memory-mapped peripheral (slave).
// din is combinational from the peripheral and valid in the same cycle as cs.
interface uart_bus_master_if #(
   parameter int WIDTH = 32
);
   logic             cs;
   logic             wen;
   logic [3:0]       addr;
   logic [WIDTH-1:0] dout;
   logic [WIDTH-1:0] din;

   modport master (output cs, output wen, output addr, output dout, input din);
   modport slave  (input cs, input wen, input addr, input dout, output din);
endinterface

// File: rtl/uart_bus_master_uart.sv
// Serial layer of the bridge: 8N1 receiver (uart_rx) and transmitter (uart_tx).
// uart_rx holds uart_rx_valid high from the stop bit of a byte until the next
// start bit, so each received byte produces exactly one rising edge. An all-zero
// frame with a low stop bit is reported as a break, held until the line idles.
module uart_rx
   import uart_bus_master_pkg::*;
#(
   parameter int cycles_per_bit = 217
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       uart_rx_en,
   input  logic       RxD,
   output logic [7:0] uart_rx_data,
   output logic       uart_rx_valid,
   output logic       uart_rx_break
);
   localparam int TW = $clog2(cycles_per_bit + 1);
   localparam logic [TW-1:0] TICK_FULL = TW'(cycles_per_bit - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(cycles_per_bit / 2 - 1);

   logic          meta_q, sync_q;
   logic [2:0]    st_q, st_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    nbit_q, nbit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          brk_q, brk_d;

   // Two-flop synchronizer for the asynchronous serial input (idles high)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         meta_q <= RxD;
         sync_q <= meta_q;
      end
   end

   // Frame decoder: centre-sample start, 8 data bits LSB first, then stop
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      st_d    = st_q;
      tick_d  = tick_q;
      nbit_d  = nbit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      brk_d   = brk_q;
      case (st_q)
         RX_IDLE: begin
            if (uart_rx_en && !sync_q) begin
               st_d    = RX_START;
               tick_d  = TICK_HALF;
               valid_d = 1'b0;
            end
         end
         RX_START: begin
            if (tick_q != '0) begin
               tick_d = tick_q - TW'(1);
            end else if (!sync_q) begin
               st_d   = RX_DATA;
               tick_d = TICK_FULL;
               nbit_d = 3'd0;
            end else begin
               st_d = RX_IDLE;   // glitch, not a start bit
            end
         end
         RX_DATA: begin
            if (tick_q != '0) begin
               tick_d = tick_q - TW'(1);
            end else begin
               shift_d = {sync_q, shift_q[7:1]};
               tick_d  = TICK_FULL;
               if (nbit_q == 3'd7) st_d = RX_STOP;
               else                nbit_d = nbit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (tick_q != '0) begin
               tick_d = tick_q - TW'(1);
            end else if (sync_q) begin
               data_d  = shift_q;
               valid_d = 1'b1;
               st_d    = RX_IDLE;
            end else begin
               brk_d = (shift_q == 8'h00);
               st_d  = RX_HOLD;
            end
         end
         RX_HOLD: begin
            if (sync_q) begin
               brk_d = 1'b0;
               st_d  = RX_IDLE;
            end
         end
         default: st_d = RX_IDLE;
      endcase
   end

   // Receiver state registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q    <= RX_IDLE;
         tick_q  <= '0;
         nbit_q  <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         brk_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         tick_q  <= tick_d;
         nbit_q  <= nbit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         brk_q   <= brk_d;
      end
   end

   assign uart_rx_data  = data_q;
   assign uart_rx_valid = valid_q;
   assign uart_rx_break = brk_q;
endmodule

module uart_tx #(
   parameter int cycles_per_bit = 217
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       uart_tx_en,
   input  logic [7:0] uart_tx_data,
   output logic       uart_tx_busy,
   output logic       TxD
);
   localparam int TW = $clog2(cycles_per_bit + 1);
   localparam logic [TW-1:0] TICK_FULL = TW'(cycles_per_bit - 1);

   logic          busy_q, busy_d;
   logic [9:0]    shreg_q, shreg_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [3:0]    nbit_q, nbit_d;

   // Load {stop, data, start} on enable, then shift one bit per bit-time
   always_comb begin
      busy_d  = busy_q;
      shreg_d = shreg_q;
      tick_d  = tick_q;
      nbit_d  = nbit_q;
      if (!busy_q) begin
         if (uart_tx_en) begin
            shreg_d = {1'b1, uart_tx_data, 1'b0};
            busy_d  = 1'b1;
            tick_d  = TICK_FULL;
            nbit_d  = 4'd0;
         end
      end else if (tick_q != '0) begin
         tick_d = tick_q - TW'(1);
      end else if (nbit_q == 4'd9) begin
         busy_d = 1'b0;   // full stop bit has been sent
      end else begin
         shreg_d = {1'b1, shreg_q[9:1]};
         nbit_d  = nbit_q + 4'd1;
         tick_d  = TICK_FULL;
      end
   end

   // Transmitter state registers; shift register idles all-ones so TxD idles high
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q  <= 1'b0;
         shreg_q <= '1;
         tick_q  <= '0;
         nbit_q  <= 4'd0;
      end else begin
         busy_q  <= busy_d;
         shreg_q <= shreg_d;
         tick_q  <= tick_d;
         nbit_q  <= nbit_d;
      end
   end

   assign uart_tx_busy = busy_q;
   assign TxD          = shreg_q[0];
endmodule

// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: receives command frames on RxD, issues one bus read or
// write, and answers on TxD (ACK 0x06 for writes, 4 data bytes MSB first for
// reads, NAK 0x15 for unknown opcodes).
// Optional: define UBM_TIMEOUT_EN to abort a stalled write frame with a NAK
// after TO_BITS bit-times without a received byte.
module uart_bus_master
   import uart_bus_master_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int CPB     = 217,
   parameter int TO_BITS = 100
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              RxD,
   output logic              TxD,
   output logic              busy,
   uart_bus_master_if.master bus
);
   // The frame format carries exactly four data bytes
   if (WIDTH != 32 || TO_BITS < 1 || CPB < 4) begin : g_bad_param
      $error("uart_bus_master: WIDTH must be 32, TO_BITS >= 1, CPB >= 4");
   end

   logic [7:0]       rx_data;
   logic             rx_valid, rx_break;
   logic             rx_valid_q;
   logic             byte_in;
   logic             tx_en, tx_busy;
   logic [7:0]       tx_data;

   logic [2:0]       state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [3:0]       addr_q, addr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             is_wr_q, is_wr_d;
   logic [WIDTH-1:0] resp_q, resp_d;
   logic [2:0]       left_q, left_d;
   logic             skip_q, skip_d;

`ifdef UBM_TIMEOUT_EN
   localparam int TO_CYC = TO_BITS * CPB;
   localparam int TOW    = $clog2(TO_CYC + 1);
   localparam logic [TOW-1:0] TO_LOAD = TOW'(TO_CYC - 1);
   logic [TOW-1:0] to_cnt_q, to_cnt_d;
`endif

   uart_rx #(.cycles_per_bit(CPB)) u_rx (
      .clk           (clk),
      .resetn        (resetn),
      .uart_rx_en    (1'b1),
      .RxD           (RxD),
      .uart_rx_data  (rx_data),
      .uart_rx_valid (rx_valid),
      .uart_rx_break (rx_break)
   );

   uart_tx #(.cycles_per_bit(CPB)) u_tx (
      .clk          (clk),
      .resetn       (resetn),
      .uart_tx_en   (tx_en),
      .uart_tx_data (tx_data),
      .uart_tx_busy (tx_busy),
      .TxD          (TxD)
   );

   // One byte-in event per rising edge of the held valid level
   assign byte_in = rx_valid && !rx_valid_q;

   // Bridge FSM: collect frame, run one bus cycle, stream the response
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      is_wr_d = is_wr_q;
      resp_d  = resp_q;
      left_d  = left_q;
      skip_d  = skip_q;
      tx_en   = 1'b0;
      tx_data = resp_q[WIDTH-1 -: 8];
`ifdef UBM_TIMEOUT_EN
      if (byte_in)                to_cnt_d = TO_LOAD;
      else if (to_cnt_q != '0)    to_cnt_d = to_cnt_q - TOW'(1);
      else                        to_cnt_d = to_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (byte_in) begin
               addr_d = rx_data[3:0];
               case (decode_cmd(rx_data))
                  CMD_READ: begin
                     is_wr_d = 1'b0;
                     state_d = ST_BUS;
                  end
                  CMD_WRITE: begin
                     is_wr_d = 1'b1;
                     cnt_d   = 2'd0;
                     state_d = ST_DATA;
                  end
                  default: begin
                     resp_d  = {RESP_NAK, {(WIDTH-8){1'b0}}};
                     left_d  = RESP_LEN_SHORT;
                     state_d = ST_RESP;
                  end
               endcase
            end
         end
         ST_DATA: begin
            if (rx_break) begin
               state_d = ST_IDLE;   // silent abort, no bus cycle
            end else if (byte_in) begin
               dout_d = {dout_q[WIDTH-9:0], rx_data};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = ST_BUS;
            end
`ifdef UBM_TIMEOUT_EN
            else if (to_cnt_q == '0) begin
               resp_d  = {RESP_NAK, {(WIDTH-8){1'b0}}};
               left_d  = RESP_LEN_SHORT;
               state_d = ST_RESP;
            end
`endif
         end
         ST_BUS: begin
            if (is_wr_q) begin
               resp_d = {RESP_ACK, {(WIDTH-8){1'b0}}};
               left_d = RESP_LEN_SHORT;
            end else begin
               resp_d = bus.din;
               left_d = RESP_LEN_READ;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (!tx_busy) begin
               tx_en   = 1'b1;
               resp_d  = {resp_q[WIDTH-9:0], 8'h00};
               left_d  = left_q - 3'd1;
               skip_d  = 1'b1;
               state_d = ST_TXWAIT;
            end
         end
         ST_TXWAIT: begin
            // First cycle is skipped so the transmitter's busy flag has risen
            if (skip_q) begin
               skip_d = 1'b0;
            end else if (!tx_busy) begin
               state_d = (left_q != 3'd0) ? ST_RESP : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bridge state registers; reset discards any partial frame
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_valid_q <= 1'b0;
         state_q    <= ST_IDLE;
         cnt_q      <= 2'd0;
         addr_q     <= 4'h0;
         dout_q     <= '0;
         is_wr_q    <= 1'b0;
         resp_q     <= '0;
         left_q     <= 3'd0;
         skip_q     <= 1'b0;
      end else begin
         rx_valid_q <= rx_valid;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         is_wr_q    <= is_wr_d;
         resp_q     <= resp_d;
         left_q     <= left_d;
         skip_q     <= skip_d;
      end
   end

`ifdef UBM_TIMEOUT_EN
   // Inter-byte timer, reloaded by every received byte
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) to_cnt_q <= TO_LOAD;
      else         to_cnt_q <= to_cnt_d;
   end
`endif

   assign bus.cs   = (state_q == ST_BUS);
   assign bus.wen  = (state_q == ST_BUS) && is_wr_q;
   assign bus.addr = addr_q;
   assign bus.dout = dout_q;
   assign busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: a host-side serializer drives RxD,
// a host-side deserializer collects TxD bytes, a peripheral memory answers the
// bus, and a frame-level reference model predicts bus cycles and responses.
module tb_uart_bus_master;
   localparam int CPB     = 16;
   localparam int TO_BITS = 20;
   localparam int WIDTH   = 32;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic RxD    = 1'b1;
   logic TxD, busy;

   int checks = 0;
   int errors = 0;
   int tx_frame_err = 0;

   uart_bus_master_if #(.WIDTH(WIDTH)) bus ();

   uart_bus_master #(.WIDTH(WIDTH), .CPB(CPB), .TO_BITS(TO_BITS)) dut (
      .clk    (clk),
      .resetn (resetn),
      .RxD    (RxD),
      .TxD    (TxD),
      .busy   (busy),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Power-on contents of the peripheral registers
   function automatic logic [31:0] init_word(input int i);
      if (i == 2) return 32'hCAFEF00D;
      return 32'h5A5A0000 ^ (32'(i) * 32'h01234567);
   endfunction

   // Peripheral: 16 registers, combinational read, write on cs&wen
   logic [31:0] mem [16];
   assign bus.din = mem[bus.addr];
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      end else if (bus.cs && bus.wen) begin
         mem[bus.addr] <= bus.dout;
      end
   end

   // Bus monitor: one entry per cycle with cs high {wen, addr, dout}
   logic [36:0] bus_log[$];
   always @(negedge clk) begin
      if (bus.cs) bus_log.push_back({bus.wen, bus.addr, bus.dout});
   end

   // Host-side deserializer for TxD
   logic [7:0] tx_bytes[$];
   initial begin : tx_mon
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (resetn && TxD === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = TxD;
            end
            repeat (CPB) @(negedge clk);
            if (TxD !== 1'b1) tx_frame_err++;
            tx_bytes.push_back(b);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [31:0] ref_mem [16];
   logic [3:0]  m_addr;
   logic [31:0] m_dout;
   bit          m_dout_known;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      m_addr       = 4'h0;
      m_dout       = 32'h0;
      m_dout_known = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      RxD = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         repeat (CPB) @(negedge clk);
      end
      RxD = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_break();
      RxD = 1'b0;
      repeat (12 * CPB) @(negedge clk);
      RxD = 1'b1;
      repeat (3 * CPB) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 300 * CPB) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, 64'(busy), 64'd0);
      repeat (4) @(negedge clk);
   endtask

   // Send one frame and compare bus activity and response with the model
   task automatic do_frame(input string tag, input logic [7:0] fr[$]);
      logic [7:0]  exp_resp[$];
      logic [36:0] exp_bus[$];
      logic [36:0] got_bus;
      logic [3:0]  a;
      logic [31:0] d;
      logic [63:0] got_b;
      a = fr[0][3:0];
      case (fr[0][7:4])
         4'hA: begin
            exp_bus.push_back({1'b0, a, m_dout});
            for (int k = 3; k >= 0; k--) exp_resp.push_back(ref_mem[a][k*8 +: 8]);
         end
         4'hB: begin
            d = {fr[1], fr[2], fr[3], fr[4]};
            exp_bus.push_back({1'b1, a, d});
            ref_mem[a]   = d;
            m_dout       = d;
            m_dout_known = 1'b1;
            exp_resp.push_back(8'h06);
         end
         default: exp_resp.push_back(8'h15);
      endcase
      m_addr = a;

      bus_log.delete();
      tx_bytes.delete();
      foreach (fr[i]) send_byte(fr[i]);
      wait_idle(tag);

      check({tag, "_ncs"}, 64'(bus_log.size()), 64'(exp_bus.size()));
      if (exp_bus.size() > 0) begin
         got_bus = (bus_log.size() > 0) ? bus_log[0] : '1;
         check({tag, "_wen"},  64'(got_bus[36]),    64'(exp_bus[0][36]));
         check({tag, "_addr"}, 64'(got_bus[35:32]), 64'(exp_bus[0][35:32]));
         if (exp_bus[0][36]) check({tag, "_dout"}, 64'(got_bus[31:0]), 64'(exp_bus[0][31:0]));
      end
      check({tag, "_nresp"}, 64'(tx_bytes.size()), 64'(exp_resp.size()));
      for (int i = 0; i < exp_resp.size(); i++) begin
         got_b = (i < tx_bytes.size()) ? 64'(tx_bytes[i]) : 64'h1FF;
         check($sformatf("%s_resp%0d", tag, i), got_b, 64'(exp_resp[i]));
      end
      check({tag, "_addr_hold"}, 64'(bus.addr), 64'(m_addr));
      if (m_dout_known) check({tag, "_dout_hold"}, 64'(bus.dout), 64'(m_dout));
   endtask

   initial begin : main
      logic [7:0] fr[$];
      logic [3:0] a, op;
      int kind;

      model_reset();
      repeat (5) @(negedge clk);
      check("rst_cs",   64'(bus.cs),   64'd0);
      check("rst_wen",  64'(bus.wen),  64'd0);
      check("rst_addr", 64'(bus.addr), 64'd0);
      check("rst_dout", 64'(bus.dout), 64'd0);
      check("rst_busy", 64'(busy),     64'd0);
      check("rst_txd",  64'(TxD),      64'd1);
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      // Directed write, read, invalid command
      fr.delete(); fr.push_back(8'hB3); fr.push_back(8'h12); fr.push_back(8'h34);
      fr.push_back(8'h56); fr.push_back(8'h78);
      do_frame("wr3", fr);
      check("wr3_dout_const", 64'(bus.dout), 64'h12345678);
      fr.delete(); fr.push_back(8'hA2);
      do_frame("rd2", fr);
      fr.delete(); fr.push_back(8'h55);
      do_frame("inv55", fr);
      fr.delete(); fr.push_back(8'hA0);
      do_frame("rd0", fr);

      // Break in DATA aborts silently
      bus_log.delete(); tx_bytes.delete();
      send_byte(8'hB1); send_byte(8'hAA);
      check("abort_busy_pre", 64'(busy), 64'd1);
      send_break();
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ncs", 64'(bus_log.size()), 64'd0);
      check("abort_nresp", 64'(tx_bytes.size()), 64'd0);
      m_addr = 4'h1; m_dout_known = 1'b0;
      fr.delete(); fr.push_back(8'hB1); fr.push_back(8'h01); fr.push_back(8'h02);
      fr.push_back(8'h03); fr.push_back(8'h04);
      do_frame("wr1", fr);

      // Break while idle is ignored
      send_break();
      fr.delete(); fr.push_back(8'hA1);
      do_frame("rd1_after_idle_break", fr);

      // Stall in DATA: timeout NAK when enabled, otherwise wait indefinitely
      bus_log.delete(); tx_bytes.delete();
      send_byte(8'hB0); send_byte(8'h11);
      repeat ((TO_BITS + 5) * CPB) @(negedge clk);
`ifdef UBM_TIMEOUT_EN
      wait_idle("tmo");
      check("tmo_nresp", 64'(tx_bytes.size()), 64'd1);
      check("tmo_nak", 64'((tx_bytes.size() > 0) ? tx_bytes[0] : 8'hFF), 64'h15);
`else
      check("tmo_busy", 64'(busy), 64'd1);
      check("tmo_nresp", 64'(tx_bytes.size()), 64'd0);
      send_break();
      check("tmo_break_busy", 64'(busy), 64'd0);
`endif
      check("tmo_ncs", 64'(bus_log.size()), 64'd0);
      m_addr = 4'h0; m_dout_known = 1'b0;

      // Reset in the middle of a write frame
      send_byte(8'hB0); send_byte(8'h11);
      check("mid_busy_pre", 64'(busy), 64'd1);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_cs",   64'(bus.cs),   64'd0);
      check("mid_wen",  64'(bus.wen),  64'd0);
      check("mid_addr", 64'(bus.addr), 64'd0);
      check("mid_dout", 64'(bus.dout), 64'd0);
      check("mid_busy", 64'(busy),     64'd0);
      check("mid_txd",  64'(TxD),      64'd1);
      resetn = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      fr.delete(); fr.push_back(8'hA0);
      do_frame("rd0_after_rst", fr);

      // Randomized frames against the model
      for (int n = 0; n < 20; n++) begin
         kind = $urandom_range(0, 2);
         a = 4'($urandom_range(0, 15));
         fr.delete();
         case (kind)
            0: fr.push_back({4'hA, a});
            1: begin
               fr.push_back({4'hB, a});
               for (int k = 0; k < 4; k++) fr.push_back(8'($urandom));
            end
            default: begin
               op = 4'($urandom_range(0, 13));
               if (op >= 4'hA) op = op + 4'd2;
               fr.push_back({op, a});
            end
         endcase
         do_frame($sformatf("rnd%0d", n), fr);
      end

      check("tx_framing", 64'(tx_frame_err), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
